// File: rtl/priority_decoder_hold_if.sv
// Handshake and status bundle between a code producer and priority_decoder_hold.
// The master drives codes and counter clears; the slave returns ready, one-hot lines and counts.
interface priority_decoder_hold_if #(
  parameter int CNT_W = 8
);
  logic [1:0]       code;
  logic             code_valid;
  logic             code_ready;
  logic             a;
  logic             b;
  logic             c;
  logic             cnt_clear;
  logic [CNT_W-1:0] cnt_none;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic [CNT_W-1:0] cnt_c;

  modport master (
    output code, code_valid, cnt_clear,
    input  code_ready, a, b, c, cnt_none, cnt_a, cnt_b, cnt_c
  );

  modport slave (
    input  code, code_valid, cnt_clear,
    output code_ready, a, b, c, cnt_none, cnt_a, cnt_b, cnt_c
  );
endinterface

// File: rtl/priority_decoder_hold.sv
// Decodes a 2-bit priority code into a registered one-hot pulse of HOLD_CYCLES,
// followed by a GAP_CYCLES idle gap, with saturating per-code event counters.
module priority_decoder_hold #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 8
) (
  input logic                    clk,
  input logic                    reset,
  priority_decoder_hold_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_INIT  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t           r_state;
  state_t           w_next_state;
  logic [7:0]       r_timer;
  logic [7:0]       w_next_timer;
  logic [2:0]       r_onehot;
  logic [2:0]       w_next_onehot;
  logic [CNT_W-1:0] r_cnt [4];
  logic             w_ready;
  logic             w_accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2:0] decode(input logic [1:0] code);
    case (code)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  assign w_accept = bus.code_valid && w_ready;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_timer  <= 8'd0;
      r_onehot <= 3'b000;
    end else begin
      r_state  <= w_next_state;
      r_timer  <= w_next_timer;
      r_onehot <= w_next_onehot;
    end
  end

  // next-state logic; the one-hot register is loaded on accept and cleared as HOLD ends
  always_comb begin
    w_next_state  = r_state;
    w_next_timer  = r_timer;
    w_next_onehot = r_onehot;
    case (r_state)
      IDLE: begin
        if (w_accept && (bus.code != 2'd0)) begin
          w_next_state  = HOLD;
          w_next_timer  = HOLD_INIT;
          w_next_onehot = decode(bus.code);
        end
      end
      HOLD: begin
        if (r_timer == 8'd0) begin
          w_next_onehot = 3'b000;
          if (GAP_CYCLES == 0) begin
            w_next_state = IDLE;
            w_next_timer = 8'd0;
          end else begin
            w_next_state = GAP;
            w_next_timer = GAP_INIT;
          end
        end else begin
          w_next_timer = r_timer - 8'd1;
        end
      end
      GAP: begin
        if (r_timer == 8'd0) begin
          w_next_state = IDLE;
        end else begin
          w_next_timer = r_timer - 8'd1;
        end
      end
      default: begin
        w_next_state  = IDLE;
        w_next_timer  = 8'd0;
        w_next_onehot = 3'b000;
      end
    endcase
  end

  // outputs: ready depends on state alone, one-hot lines come straight from a register
  always_comb begin
    w_ready        = (r_state == IDLE);
    bus.code_ready = w_ready;
    bus.a          = r_onehot[0];
    bus.b          = r_onehot[1];
    bus.c          = r_onehot[2];
  end

  // clear wins over a same-edge increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else if (bus.cnt_clear) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else if (w_accept) begin
      r_cnt[bus.code] <= sat_inc(r_cnt[bus.code]);
    end
  end

  assign bus.cnt_none = r_cnt[0];
  assign bus.cnt_a    = r_cnt[1];
  assign bus.cnt_b    = r_cnt[2];
  assign bus.cnt_c    = r_cnt[3];

endmodule

// File: doc/priority_decoder_hold.md
# priority_decoder_hold

Sequential decoder for the 2-bit priority code produced by the team's 3-input priority encoder (z = 0: none, 1: a, 2: b, 3: c). It accepts one code per valid/ready handshake. It drives the matching one-hot line {c,b,a} for a programmable number of cycles, then holds a programmable idle gap before accepting the next code. Saturating per-code event counters let the bench and downstream logic check the code stream.

## Interface
- HOLD_CYCLES, default 4: cycles the one-hot output stays asserted; legal range 1..255.
- GAP_CYCLES, default 1: all-zero cycles after the hold, before ready returns; legal range 0..255.
- CNT_W, default 8: width of each event counter.
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- code  input  2  priority code: 0 = none, 1 = a, 2 = b, 3 = c.
- code_valid  input  1  code is presented this cycle.
- code_ready  output  1  block can accept a code this cycle.
- a, b, c  output  1 each  decoded one-hot lines; at most one is high at any time.
- cnt_clear  input  1  synchronous clear of all event counters.
- cnt_none, cnt_a, cnt_b, cnt_c  output  CNT_W each  count of accepted codes 0, 1, 2, 3 respectively.

## Operation
- States: IDLE, HOLD, GAP. An 8-bit down-timer is shared by HOLD and GAP.
- code_ready = (state == IDLE). It is combinational from state only, with no dependence on code_valid.
- Accept occurs on a rising edge where code_valid && code_ready.
- IDLE, accept of code 0:
  - increment cnt_none;
  - stay in IDLE; outputs stay 0.
- IDLE, accept of code 1/2/3:
  - register the one-hot value: 1 → a, 2 → b, 3 → c;
  - increment the matching counter;
  - enter HOLD with timer = HOLD_CYCLES-1.
- HOLD:
  - one-hot output held; code_ready = 0; code_valid is ignored;
  - timer decrements each edge;
  - on the edge where timer == 0: clear outputs, then enter GAP with timer = GAP_CYCLES-1, or enter IDLE if GAP_CYCLES == 0.
- GAP:
  - outputs 0, code_ready = 0;
  - timer decrements each edge; enter IDLE on the edge where timer == 0.
- Counters:
  - saturate at 2^CNT_W-1 and never wrap;
  - cnt_clear zeroes all four on the next edge;
  - cnt_clear has priority over a same-edge increment, so the result is 0.
- Decoder outputs are registered. There is no combinational path from code to a/b/c.

## Timing
- Reset asserted:
  - state = IDLE; a = b = c = 0; all counters = 0; timer = 0;
  - outputs clear immediately, without waiting for a clock edge, including in the middle of HOLD or GAP;
  - code_valid during reset is ignored;
  - first accept is possible on the first edge after reset deasserts.
- Accept of a nonzero code at edge t0:
  - one-hot output is high after t0, through the edge t0+HOLD_CYCLES (exactly HOLD_CYCLES cycles);
  - code_ready returns high after edge t0+HOLD_CYCLES+GAP_CYCLES;
  - earliest next accept is at edge t0+HOLD_CYCLES+GAP_CYCLES+1.
- Accept of code 0 at edge t0: code_ready stays high, so back-to-back zero codes are accepted every cycle.
- Counter update is visible one cycle after the accepting edge.
- A code held valid while not ready is not consumed and not counted. It is accepted on the first edge where ready is high.

## Test plan
- Reset, then code = 2 with code_valid for 1 cycle (defaults HOLD = 4, GAP = 1):
  - b = 1 for exactly 4 cycles, a = c = 0;
  - ready low for 5 cycles;
  - cnt_b = 1, all other counters 0.
- Sweep codes 0, 1, 2, 3, with code_valid held high the whole time:
  - each code is accepted exactly once;
  - outputs a, b, c each pulse 4 cycles in that order, with code 0 producing no pulse;
  - all four counters = 1.
- Code 3 accepted, reset asserted in the 2nd HOLD cycle:
  - c drops immediately;
  - ready = 1 and counters = 0 after release;
  - a new code 1 is accepted on the first edge after release.
- Rebuild with CNT_W = 2 and send 5 zero codes back-to-back: cnt_none goes 1, 2, 3, 3, 3 and ready stays 1 throughout.
- Assert cnt_clear on the same edge that accepts code 1: cnt_a = 0 after that edge, and a still pulses for 4 cycles.
- Rebuild with HOLD = 1, GAP = 0 and send code 1 continuously: a pulses 1 cycle, with accepts every 2nd edge.
